// File: rtl/fixed_scaler_if.sv
// Operand/result handshake bundle for fixed_scaler.
// Producer side uses the master modport, the scaler uses the slave modport.
interface fixed_scaler_if #(
    parameter int unsigned WIDTH_A = 8,
    parameter int unsigned WIDTH_B = 8,
    parameter int unsigned WIDTH_Y = 8
);
    logic               ipValid;
    logic               opReady;
    logic [WIDTH_A-1:0] ipA;
    logic [WIDTH_B-1:0] ipB;
    logic               ipA_Signed;
    logic               ipB_Signed;
    logic               ipRound;
    logic               opValid;
    logic               ipReady;
    logic [WIDTH_Y-1:0] opY;
    logic               opOverflow;

    modport master (
        output ipValid, ipA, ipB, ipA_Signed, ipB_Signed, ipRound, ipReady,
        input  opReady, opValid, opY, opOverflow
    );

    modport slave (
        input  ipValid, ipA, ipB, ipA_Signed, ipB_Signed, ipRound, ipReady,
        output opReady, opValid, opY, opOverflow
    );
endinterface

// File: rtl/fixed_scaler.sv
// Three-stage fixed-point multiply, shift, round and range-check pipeline.
// Define FIXED_SCALER_SATURATE_EN to clamp overflowing results instead of wrapping.
module fixed_scaler #(
    parameter int unsigned WIDTH_A = 8,
    parameter int unsigned WIDTH_B = 8,
    parameter int unsigned WIDTH_Y = 8,
    parameter int unsigned SHIFT   = 4
) (
    input logic           Clk,
    input logic           nReset,
    fixed_scaler_if.slave bus
);

    localparam int unsigned PW = WIDTH_A + WIDTH_B + 2;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned CW = (SW > WIDTH_Y + 2) ? SW : WIDTH_Y + 2;

    // Range limits as CW-bit two's complement patterns
    localparam logic [CW-1:0] LIM_S = CW'(1) << (WIDTH_Y - 1);
    localparam logic [CW-1:0] S_MAX = LIM_S - CW'(1);
    localparam logic [CW-1:0] S_MIN = CW'(0) - LIM_S;
    localparam logic [CW-1:0] U_MAX = (CW'(1) << WIDTH_Y) - CW'(1);
    localparam logic [SW-1:0] RND_BIAS = (SW'(1) << SHIFT) >> 1;

    logic en;

    logic                      s1_valid;
    logic signed [WIDTH_A:0]   s1_a;
    logic signed [WIDTH_B:0]   s1_b;
    logic                      s1_sgn;
    logic                      s1_rnd;

    logic                      s2_valid;
    logic signed [PW-1:0]      s2_prod;
    logic                      s2_sgn;
    logic                      s2_rnd;

    logic                      s3_valid;
    logic [WIDTH_Y-1:0]        s3_y;
    logic                      s3_ovf;

    logic signed [WIDTH_A:0]   a_ext_c;
    logic signed [WIDTH_B:0]   b_ext_c;
    logic signed [PW-1:0]      prod_c;
    logic signed [SW-1:0]      bias_c;
    logic signed [SW-1:0]      sum_c;
    logic signed [SW-1:0]      shifted_c;
    logic signed [CW-1:0]      val_c;
    logic                      ovf_c;
    logic                      neg_c;
    logic [WIDTH_Y-1:0]        y_c;

    // Whole pipeline moves together whenever the output slot can drain
    assign en          = bus.ipReady || !s3_valid;
    assign bus.opReady = en;
    assign bus.opValid = s3_valid;
    assign bus.opY     = s3_y;
    assign bus.opOverflow = s3_ovf;

    // Operand extension to one extra bit, signed or zero fill per mode
    always_comb begin
        a_ext_c = '0;
        b_ext_c = '0;
        if (bus.ipA_Signed) a_ext_c = {bus.ipA[WIDTH_A-1], bus.ipA};
        else                a_ext_c = {1'b0, bus.ipA};
        if (bus.ipB_Signed) b_ext_c = {bus.ipB[WIDTH_B-1], bus.ipB};
        else                b_ext_c = {1'b0, bus.ipB};
    end

    assign prod_c = PW'(s1_a) * PW'(s1_b);

    // Round-half-up bias, arithmetic shift, then range check and wrap/clamp
    always_comb begin
        bias_c    = '0;
        sum_c     = '0;
        shifted_c = '0;
        val_c     = '0;
        ovf_c     = 1'b0;
        neg_c     = 1'b0;
        y_c       = '0;

        if (s2_rnd) bias_c = $signed(RND_BIAS);
        sum_c     = SW'(s2_prod) + bias_c;
        shifted_c = sum_c >>> SHIFT;
        val_c     = CW'(shifted_c);
        neg_c     = val_c[CW-1];

        if (s2_sgn) ovf_c = (val_c > $signed(S_MAX)) || (val_c < $signed(S_MIN));
        else        ovf_c = neg_c || (val_c > $signed(U_MAX));

`ifdef FIXED_SCALER_SATURATE_EN
        if (ovf_c) begin
            if (neg_c) y_c = s2_sgn ? S_MIN[WIDTH_Y-1:0] : '0;
            else       y_c = s2_sgn ? S_MAX[WIDTH_Y-1:0] : U_MAX[WIDTH_Y-1:0];
        end else begin
            y_c = val_c[WIDTH_Y-1:0];
        end
`else
        y_c = val_c[WIDTH_Y-1:0];
`endif
    end

    // S1: capture extended operands together with their mode bits
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sgn   <= 1'b0;
            s1_rnd   <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.ipValid;
            s1_a     <= a_ext_c;
            s1_b     <= b_ext_c;
            s1_sgn   <= bus.ipA_Signed || bus.ipB_Signed;
            s1_rnd   <= bus.ipRound;
        end
    end

    // S2: exact product
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_sgn   <= 1'b0;
            s2_rnd   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_prod  <= prod_c;
            s2_sgn   <= s1_sgn;
            s2_rnd   <= s1_rnd;
        end
    end

    // S3: scaled result; data only refreshes on a real transaction
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            s3_valid <= 1'b0;
            s3_y     <= '0;
            s3_ovf   <= 1'b0;
        end else if (en) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_y   <= y_c;
                s3_ovf <= ovf_c;
            end
        end
    end

endmodule

// File: doc/fixed_scaler.md
FIXED_SCALER -- requirements
Module: fixed_scaler

Interface
REQ-001 SHALL have parameter WIDTH_A, default 8, operand A width (2..32).
REQ-002 SHALL have parameter WIDTH_B, default 8, operand B width (2..32).
REQ-003 SHALL have parameter WIDTH_Y, default 8, result width (2..32).
REQ-004 SHALL have parameter SHIFT, default 4, right-shift applied to product (0..WIDTH_A+WIDTH_B).
REQ-005 SHALL have port Clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port nReset  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port ipValid  input  1  upstream operand valid.
REQ-008 SHALL have port opReady  output  1  block accepts operands this cycle.
REQ-009 SHALL have port ipA  input  WIDTH_A  operand A.
REQ-010 SHALL have port ipB  input  WIDTH_B  operand B.
REQ-011 SHALL have port ipA_Signed  input  1  A is two's complement when 1, unsigned when 0.
REQ-012 SHALL have port ipB_Signed  input  1  B is two's complement when 1, unsigned when 0.
REQ-013 SHALL have port ipRound  input  1  round-half-up when 1, floor (truncate toward -inf) when 0.
REQ-014 SHALL have port opValid  output  1  result valid.
REQ-015 SHALL have port ipReady  input  1  downstream accepts result.
REQ-016 SHALL have port opY  output  WIDTH_Y  scaled result.
REQ-017 SHALL have port opOverflow  output  1  result exceeded WIDTH_Y range; qualified by opValid.

Function
REQ-018 SHALL transfer input when ipValid && opReady; output when opValid && ipReady.
REQ-019 SHALL be a 3-stage pipeline: S1 register/extend operands + mode, S2 full product, S3 shift/round/clamp; latency 3 cycles with no stall.
REQ-020 SHALL use pipeline enable EN = ipReady || !opValid; opReady = EN; all stages advance only when EN; stages hold when !EN.
REQ-021 SHALL sustain one transfer per cycle when ipReady stays high; bubbles propagate unchanged (not collapsed).
REQ-022 SHALL latch ipA_Signed, ipB_Signed, ipRound with the operand; mode changes never affect in-flight data.
REQ-023 SHALL extend each operand to WIDTH+1 bits signed (sign-extend if signed, zero-extend if unsigned) and form an exact WIDTH_A+WIDTH_B+2 bit signed product.
REQ-024 SHALL, when Round=1 and SHIFT>0, add 2^(SHIFT-1) before arithmetic right shift by SHIFT; Round has no effect when SHIFT=0.
REQ-025 SHALL treat result as signed when A_Signed||B_Signed, else unsigned.
REQ-026 SHALL flag overflow when shifted value lies outside [-2^(WIDTH_Y-1), 2^(WIDTH_Y-1)-1] (signed) or [0, 2^WIDTH_Y-1] (unsigned).
REQ-027 SHALL keep opY/opOverflow stable while opValid && !ipReady.
REQ-028 SHALL never drop or duplicate a transaction; output order equals input order.

Reset
REQ-029 SHALL, on Clk edge with nReset=0, clear all stage valids; opValid=0, opY=0, opOverflow=0.
REQ-030 SHALL discard in-flight data on reset mid-operation; opReady=1 on first cycle after reset release.
REQ-031 SHALL ignore ipValid during reset.

Configuration
REQ-032 SHALL with macro FIXED_SCALER_SATURATE_EN defined clamp overflowing results to the range limit in the overflow direction (REQ-026 bounds).
REQ-033 SHALL without FIXED_SCALER_SATURATE_EN output low WIDTH_Y bits (wrap); opOverflow still computed identically.

Verification
REQ-034 SHALL cover: defaults, unsigned, A=0xFF B=0xFF Round=0 -> opY=0xFF Overflow=1 (SATURATE_EN) / opY=0xE0 Overflow=1 (no macro), 3 cycles after accept.
REQ-035 SHALL cover: both signed, A=0x80 B=0x80 -> 1024 -> opY=0x7F Overflow=1 (SATURATE_EN); A=0x80 B=0x7F -> -1016 -> opY=0x80 Overflow=1.
REQ-036 SHALL cover: A signed 0xFF, B unsigned 0x7F -> -127 -> opY=0xF8 for Round=0 and Round=1; A=0x18 B=0x01 unsigned -> opY=0x01 Round=0, 0x02 Round=1.
REQ-037 SHALL cover: 6 back-to-back transfers, ipReady low for 2 cycles mid-stream -> opReady low same cycles, opY held, all 6 results in order, none lost.
REQ-038 SHALL cover: nReset=0 with 3 transactions in flight -> next cycle opValid=0 opY=0; no stale result after release.
REQ-039 SHALL cover: A=0x00 B=0xFF all four sign modes -> opY=0x00 Overflow=0.
